motor_bus_scheduler: RTL and testbench

//  Owns the shared 4-axis motor register bus (per-axis chip select, common addr/data).

---
 rtl/motor_bus_pkg.sv | 33 +++
 rtl/motor_poll_timer.sv | 42 ++++
 rtl/motor_bus_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_motor_bus_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_bus_pkg.sv
// Shared definitions for the 4-axis motor register bus scheduler:
// bus widths, axis encodings, phase FSM states and the default poll address.
package motor_bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_AXIS = 4;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;
  localparam logic [1:0] AXIS_W = 2'd3;

  localparam logic [ADDR_W-1:0] STATUS_ADDR_DEF = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } bus_state_e;

  typedef enum logic {
    GRANT_HOST,
    GRANT_POLL
  } grant_e;

  // Active-low one-hot chip select for the given axis.
  function automatic logic [N_AXIS-1:0] axis_cs_n(input logic [1:0] axis);
    return ~(N_AXIS'(1) << axis);
  endfunction

endpackage

// File: rtl/motor_poll_timer.sv
// Periodic status-poll request generator: free-running period counter,
// sticky pending flag and round-robin axis pointer.
module motor_poll_timer
  import motor_bus_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_grant,
  input  logic       poll_done,
  output logic       poll_pending,
  output logic [1:0] poll_axis
);

  localparam int unsigned CNT_W = $clog2(POLL_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_W'(POLL_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      poll_pending <= 1'b0;
      poll_axis    <= AXIS_X;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      // A tick landing on the grant cycle re-arms the request rather than being lost.
      if (wrap) begin
        poll_pending <= 1'b1;
      end else if (poll_grant) begin
        poll_pending <= 1'b0;
      end
      if (poll_done) begin
        poll_axis <= poll_axis + 2'd1;
      end
    end
  end

endmodule

// File: rtl/motor_bus_scheduler.sv
// Shared 4-axis motor register bus owner: arbitrates host commands against the
// periodic status poller and sequences setup/strobe/hold bus transactions.
module motor_bus_scheduler
  import motor_bus_pkg::*;
#(
  parameter int unsigned       SETUP_CYC   = 1,
  parameter int unsigned       STROBE_CYC  = 2,
  parameter int unsigned       HOLD_CYC    = 1,
  parameter int unsigned       POLL_PERIOD = 1000,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [1:0]               cmd_axis,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [N_AXIS-1:0]        motor_cs_n,
  output logic [ADDR_W-1:0]        motor_addr,
  output logic                     motor_oe_n,
  output logic                     motor_we_n,
  output logic [DATA_W-1:0]        motor_data_o,
  output logic                     motor_data_t,
  input  logic [DATA_W-1:0]        motor_data_i,
  output logic [N_AXIS*DATA_W-1:0] status_q,
  output logic [N_AXIS-1:0]        status_upd
);

  localparam int unsigned MAX_PH = (SETUP_CYC > STROBE_CYC)
                                   ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                   : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int unsigned CNT_W  = $clog2(MAX_PH) + 1;

  bus_state_e       state, state_nx;
  logic [CNT_W-1:0] ph_cnt, ph_cnt_nx;
  logic             phase_end;
  grant_e           last_grant;
  logic             host_gnt, poll_gnt, poll_done;
  logic             poll_pending;
  logic [1:0]       poll_axis;

  logic             txn_poll, txn_write;
  logic [1:0]       txn_axis;
  logic [DATA_W-1:0] rd_cap;

  motor_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD)
  ) u_poll_timer (
    .clk          (clk),
    .rst          (rst),
    .poll_grant   (poll_gnt),
    .poll_done    (poll_done),
    .poll_pending (poll_pending),
    .poll_axis    (poll_axis)
  );

  assign phase_end = (ph_cnt == '0);
  assign cmd_ready = host_gnt;

  always_comb begin
    state_nx  = state;
    ph_cnt_nx = ph_cnt;
    host_gnt  = 1'b0;
    poll_gnt  = 1'b0;
    poll_done = 1'b0;
    case (state)
      ST_IDLE: begin
        // Under contention the side that did not win last time goes next.
        if (cmd_valid && (!poll_pending || last_grant == GRANT_POLL)) begin
          host_gnt = 1'b1;
        end else if (poll_pending) begin
          poll_gnt = 1'b1;
        end
        if (host_gnt || poll_gnt) begin
          state_nx  = ST_SETUP;
          ph_cnt_nx = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_nx  = ST_STROBE;
          ph_cnt_nx = CNT_W'(STROBE_CYC - 1);
        end else begin
          ph_cnt_nx = ph_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (phase_end) begin
          state_nx  = ST_HOLD;
          ph_cnt_nx = CNT_W'(HOLD_CYC - 1);
        end else begin
          ph_cnt_nx = ph_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_end) begin
          state_nx  = ST_IDLE;
          poll_done = txn_poll;
        end else begin
          ph_cnt_nx = ph_cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      ph_cnt <= '0;
    end else begin
      state  <= state_nx;
      ph_cnt <= ph_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= GRANT_POLL;
      txn_poll     <= 1'b0;
      txn_write    <= 1'b0;
      txn_axis     <= AXIS_X;
      rd_cap       <= '0;
      motor_cs_n   <= '1;
      motor_addr   <= '0;
      motor_oe_n   <= 1'b1;
      motor_we_n   <= 1'b1;
      motor_data_o <= '0;
      motor_data_t <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      status_q     <= '0;
      status_upd   <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      status_upd <= '0;
      case (state)
        ST_IDLE: begin
          if (host_gnt) begin
            last_grant   <= GRANT_HOST;
            txn_poll     <= 1'b0;
            txn_write    <= cmd_write;
            txn_axis     <= cmd_axis;
            motor_cs_n   <= axis_cs_n(cmd_axis);
            motor_addr   <= cmd_addr;
            motor_data_o <= cmd_write ? cmd_wdata : '0;
            motor_data_t <= ~cmd_write;
          end else if (poll_gnt) begin
            last_grant   <= GRANT_POLL;
            txn_poll     <= 1'b1;
            txn_write    <= 1'b0;
            txn_axis     <= poll_axis;
            motor_cs_n   <= axis_cs_n(poll_axis);
            motor_addr   <= STATUS_ADDR;
            motor_data_o <= '0;
            motor_data_t <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            motor_we_n <= ~txn_write;
            motor_oe_n <= txn_write;
          end
        end
        ST_STROBE: begin
          if (phase_end) begin
            motor_we_n <= 1'b1;
            motor_oe_n <= 1'b1;
            rd_cap     <= motor_data_i;
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            motor_cs_n   <= '1;
            motor_data_t <= 1'b1;
            if (txn_poll) begin
              status_q[{txn_axis, 5'd0} +: DATA_W] <= rd_cap;
              status_upd[txn_axis]                 <= 1'b1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= txn_write ? '0 : rd_cap;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_bus_scheduler.sv
// Randomized bench for motor_bus_scheduler: three timing configurations run side by
// side, each against a transaction-timeline model of grants, phases and completions.
module tb_motor_bus_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int S = (g == 0) ? 1 : (g == 1) ? 1 : 3;
    localparam int T = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int H = (g == 0) ? 1 : (g == 1) ? 1 : 2;
    localparam int P = (g == 0) ? 1000 : (g == 1) ? 16 : 20;
    localparam int D = S + T + H + 1;

    logic         rst, cmd_valid, cmd_ready, cmd_write;
    logic [1:0]   cmd_axis;
    logic [7:0]   cmd_addr, motor_addr;
    logic [31:0]  cmd_wdata, rsp_rdata, motor_data_o, motor_data_i;
    logic         rsp_valid, motor_oe_n, motor_we_n, motor_data_t;
    logic [3:0]   motor_cs_n, status_upd;
    logic [127:0] status_q;

    motor_bus_scheduler #(
      .SETUP_CYC   (S),
      .STROBE_CYC  (T),
      .HOLD_CYC    (H),
      .POLL_PERIOD (P),
      .STATUS_ADDR (8'h10)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_write    (cmd_write),
      .cmd_axis     (cmd_axis),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .motor_cs_n   (motor_cs_n),
      .motor_addr   (motor_addr),
      .motor_oe_n   (motor_oe_n),
      .motor_we_n   (motor_we_n),
      .motor_data_o (motor_data_o),
      .motor_data_t (motor_data_t),
      .motor_data_i (motor_data_i),
      .status_q     (status_q),
      .status_upd   (status_upd)
    );

    // Model: cycle index since reset release, grant cycle of the transaction in flight.
    int        n, g0;
    bit        pend, last_host, has_txn, t_poll, t_wr, acc, fixed_en, done;
    bit [1:0]  paxis, t_axis;
    bit [7:0]  t_addr;
    bit [31:0] t_wdata, cap, fixed_val, last_rdata;
    bit [31:0] shadow [4];

    task automatic model_reset();
      n = 0; g0 = 0; pend = 0; last_host = 0; has_txn = 0; paxis = 0; acc = 0;
      for (int i = 0; i < 4; i++) shadow[i] = '0;
    endtask

    task automatic rand_fields();
      cmd_write = 1'($urandom_range(0, 1));
      cmd_axis  = 2'($urandom_range(0, 3));
      cmd_addr  = 8'($urandom_range(0, 255));
      cmd_wdata = $urandom;
    endtask

    task automatic reset_checks(input string tag);
      check({tag, "_ctl"}, {motor_cs_n, motor_oe_n, motor_we_n, motor_data_t}, 7'h7F);
      check({tag, "_addr_data"}, {motor_addr, motor_data_o}, '0);
      check({tag, "_rsp"}, {cmd_ready, rsp_valid, rsp_rdata}, '0);
      check({tag, "_status"}, {status_upd, status_q}, '0);
    endtask

    // One clock cycle: drive bus data, compare against the timeline, advance the model.
    task automatic cycle();
      bit        e_rsp, gh, gp, e_oe, e_we, e_dt;
      bit [3:0]  e_upd, e_cs;
      bit [31:0] e_rdata;
      int        k;
      motor_data_i = fixed_en ? fixed_val : $urandom;
      #1;
      e_rsp = 0; e_upd = '0; e_rdata = '0;
      if (has_txn && n == g0 + D) begin
        if (t_poll) begin
          shadow[t_axis] = cap;
          e_upd = 4'b1 << t_axis;
          paxis = paxis + 2'd1;
        end else begin
          e_rsp = 1;
          e_rdata = t_wr ? '0 : cap;
        end
        has_txn = 0;
      end
      e_cs = 4'hF; e_oe = 1; e_we = 1; e_dt = 1;
      if (has_txn) begin
        k = n - g0;
        e_cs = ~(4'b1 << t_axis);
        e_dt = ~t_wr;
        if (k > S && k <= S + T) begin
          e_oe = t_wr;
          e_we = ~t_wr;
        end
      end
      gh = !has_txn && cmd_valid && (!pend || !last_host);
      gp = !has_txn && !gh && pend;
      check($sformatf("c%0d_ctl@%0d", g, n),
            {motor_cs_n, motor_oe_n, motor_we_n, motor_data_t}, {e_cs, e_oe, e_we, e_dt});
      check($sformatf("c%0d_cmd_ready@%0d", g, n), cmd_ready, gh);
      check($sformatf("c%0d_rsp_valid@%0d", g, n), rsp_valid, e_rsp);
      check($sformatf("c%0d_status_upd@%0d", g, n), status_upd, e_upd);
      check($sformatf("c%0d_status_q@%0d", g, n), status_q,
            {shadow[3], shadow[2], shadow[1], shadow[0]});
      if (e_rsp) begin
        check($sformatf("c%0d_rsp_rdata@%0d", g, n), rsp_rdata, e_rdata);
        last_rdata = rsp_rdata;
      end
      if (has_txn) begin
        check($sformatf("c%0d_addr@%0d", g, n), motor_addr, t_addr);
        if (t_wr) check($sformatf("c%0d_data_o@%0d", g, n), motor_data_o, t_wdata);
      end
      if (has_txn && n == g0 + S + T) cap = motor_data_i;
      acc = gh;
      if (gh || gp) begin
        has_txn = 1; g0 = n; t_poll = gp; last_host = gh;
        t_wr    = gh && cmd_write;
        t_axis  = gh ? cmd_axis : paxis;
        t_addr  = gh ? cmd_addr : 8'h10;
        t_wdata = cmd_wdata;
      end
      pend = ((n + 1) % P == 0) ? 1'b1 : (gp ? 1'b0 : pend);
      n++;
      @(negedge clk);
    endtask

    task automatic host_cmd(input bit w, input bit [1:0] a, input bit [7:0] ad,
                            input bit [31:0] d);
      int i;
      cmd_write = w; cmd_axis = a; cmd_addr = ad; cmd_wdata = d; cmd_valid = 1;
      i = 0;
      acc = 0;
      while (!acc && i < 3 * D + 4) begin
        cycle();
        i++;
      end
      if (!acc) check($sformatf("c%0d_host_accept_timeout", g), 0, 1);
      cmd_valid = 0;
      rand_fields();
      i = 0;
      while (has_txn && i < D + 2) begin
        cycle();
        i++;
      end
      cycle();
    endtask

    initial begin
      done = 0; fixed_en = 0; fixed_val = '0; last_rdata = '0; cap = '0;
      rst = 1; cmd_valid = 0; motor_data_i = '0;
      rand_fields();
      model_reset();
      @(negedge clk);
      #1;
      reset_checks($sformatf("c%0d_reset", g));
      rst = 0;
      cycle();

      host_cmd(1, 2'd2, 8'h05, 32'hDEADBEEF);
      check($sformatf("c%0d_t1_rdata", g), last_rdata, 32'h0);
      last_rdata = 32'hFFFF_FFFF;
      fixed_en = 1; fixed_val = 32'h12345678;
      host_cmd(0, 2'd0, 8'h01, 32'h0);
      fixed_en = 0;
      check($sformatf("c%0d_t2_rdata", g), last_rdata, 32'h12345678);

      for (int i = 0; i < 4 * P + 2 * D + 4; i++) begin
        rand_fields();
        cycle();
      end

      cmd_valid = 1;
      for (int i = 0; i < P + 8 * D; i++) begin
        cycle();
        if (acc) rand_fields();
      end
      cmd_valid = 0;

      for (int i = 0; i < 600; i++) begin
        cycle();
        if (acc) cmd_valid = 0;
        if (!cmd_valid) begin
          rand_fields();
          cmd_valid = ($urandom_range(0, 2) == 0);
        end
      end
      cmd_valid = 0;
      for (int i = 0; i < D + 2; i++) cycle();

      // Abort a write while its strobe is active.
      cmd_write = 1; cmd_axis = 2'd1; cmd_addr = 8'h22; cmd_wdata = 32'hA5A5_0F0F;
      cmd_valid = 1;
      for (int i = 0; i < 3 * D + 4 && !acc; i++) cycle();
      cmd_valid = 0;
      for (int i = 0; i < D && !(has_txn && !t_poll && n - g0 == S + 1); i++) cycle();
      check($sformatf("c%0d_t5_in_strobe", g), {has_txn, motor_we_n}, 2'b10);
      #2;
      rst = 1;
      #1;
      check($sformatf("c%0d_t5_async_release", g),
            {motor_cs_n, motor_oe_n, motor_we_n, motor_data_t, rsp_valid}, 8'hFE);
      @(posedge clk);
      @(negedge clk);
      reset_checks($sformatf("c%0d_t5_reset", g));
      rst = 0;
      model_reset();
      cycle();
      last_rdata = '0;
      fixed_en = 1; fixed_val = 32'hCAFE_0042;
      host_cmd(0, 2'd3, 8'h33, 32'h0);
      fixed_en = 0;
      check($sformatf("c%0d_t5_after_reset_rdata", g), last_rdata, 32'hCAFE_0042);

      for (int i = 0; i < 200; i++) begin
        cycle();
        if (acc) cmd_valid = 0;
        if (!cmd_valid) begin
          rand_fields();
          cmd_valid = ($urandom_range(0, 1) == 0);
        end
      end
      cmd_valid = 0;
      for (int i = 0; i < D + 2; i++) cycle();
      done = 1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (!(cfg[0].done && cfg[1].done && cfg[2].done)) check("run_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
